// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the SRAM bank arbiter.
package sram_arb_pkg;

  typedef enum logic {
    INIT,
    RUN
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MEM_DEPTH  = 6144;

  // Requester index is stored binary in the tag, so up to 256 requesters.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
    logic                err;
  } rsp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner only on a grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] r_ptr;

  // First pass looks at or above the pointer, second pass wraps to the bottom.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_en && !o_any && i_valid[i] && (IDX_W'(i) >= r_ptr)) begin
        o_any      = 1'b1;
        o_idx      = IDX_W'(i);
        o_grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_en && !o_any && i_valid[i]) begin
        o_any      = 1'b1;
        o_idx      = IDX_W'(i);
        o_grant[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Arbitrates NUM_REQ requesters onto one single-port SRAM and routes read responses back.
// Define SRAM_ARB_INIT_EN to compile in the post-reset zero-fill sweep (INIT state).
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic                          init_done,
  output logic [ADDR_WIDTH-1:0]         mem_A,
  output logic                          mem_CEB,
  output logic                          mem_WEB,
  output logic [DATA_WIDTH-1:0]         mem_D,
  input  logic [DATA_WIDTH-1:0]         mem_Q
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  arb_state_t              w_state;
  logic [ADDR_WIDTH-1:0]   w_sweep_a;
  logic                    w_en;
  logic                    w_any;
  logic [NUM_REQ-1:0]      w_grant;
  logic [IDX_W-1:0]        w_idx;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic                    w_we;
  logic                    w_in_range;
  rsp_tag_t                r_tag;

`ifdef SRAM_ARB_INIT_EN
  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == INIT) ? r_cnt + ADDR_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == INIT && r_cnt == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
      w_state_nxt = RUN;
    end
  end

  assign w_state   = r_state;
  assign w_sweep_a = r_cnt;
`else
  assign w_state   = RUN;
  assign w_sweep_a = '0;
`endif

  assign w_en      = (w_state == RUN) && !RST;
  assign init_done = (w_state == RUN);
  assign req_ready = w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .CLK     (CLK),
    .RST     (RST),
    .i_en    (w_en),
    .i_valid (req_valid),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_we    = req_we[i];
      end
    end
  end

  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);

  // Out-of-range accesses are accepted but never reach the macro.
  always_comb begin
    mem_CEB = 1'b1;
    mem_WEB = 1'b1;
    mem_A   = '0;
    mem_D   = '0;
    if (!RST) begin
      if (w_state == INIT) begin
        mem_CEB = 1'b0;
        mem_WEB = 1'b0;
        mem_A   = w_sweep_a;
      end else if (w_any) begin
        mem_CEB = !w_in_range;
        mem_WEB = !w_we;
        mem_A   = w_addr;
        mem_D   = w_wdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tag <= '0;
    end else begin
      r_tag.vld <= w_any && !w_we;
      r_tag.id  <= TAG_ID_W'(w_idx);
      r_tag.err <= !w_in_range;
    end
  end

  // Memory holds Q across writes, so the tag alone qualifies mem_Q one cycle later.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    if (r_tag.vld && !RST) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_tag.id == TAG_ID_W'(i)) rsp_valid[i] = 1'b1;
      end
      rsp_err  = r_tag.err;
      rsp_data = r_tag.err ? '0 : mem_Q;
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Self-checking bench for sram_bank_arbiter with a behavioural SRAM and reference model.
module tb_sram_bank_arbiter;

  localparam int N     = 2;
  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 6144;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            init_done;
  logic [AW-1:0]   mem_A;
  logic            mem_CEB;
  logic            mem_WEB;
  logic [DW-1:0]   mem_D;
  logic [DW-1:0]   mem_Q = '0;

  always #5 CLK = ~CLK;

  sram_bank_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .mem_A     (mem_A),
    .mem_CEB   (mem_CEB),
    .mem_WEB   (mem_WEB),
    .mem_D     (mem_D),
    .mem_Q     (mem_Q)
  );

  // Behavioural single-port SRAM: 1-cycle read, Q held during writes.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge CLK) begin
    if (!mem_CEB && (int'(mem_A) < DEPTH)) begin
      if (!mem_WEB) sram[mem_A] <= mem_D;
      else          mem_Q <= sram[mem_A];
    end
  end

  // Reference model state.
  int            errors = 0;
  int            checks = 0;
  int            rr_ptr;
  logic [DW-1:0] ref_mem [DEPTH];
  int            exp_g;
  logic [N-1:0]  exp_ready;
  logic          exp_ceb;
  logic [N-1:0]  exp_rv;
  logic          exp_err;
  logic [DW-1:0] exp_data;
  logic [AW-1:0] cur_a [N];
  logic [DW-1:0] cur_d [N];
  logic [N-1:0]  cur_v;
  logic [N-1:0]  cur_w;
  int            init_cycles;
  int            ready_viol;

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    cur_v = v; cur_w = w;
    cur_a[0] = a0; cur_a[1] = a1;
    cur_d[0] = d0; cur_d[1] = d1;
    req_valid = v; req_we = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    exp_g = -1;
    for (int k = 0; k < N; k++) begin
      if (exp_g < 0 && v[(rr_ptr + k) % N]) exp_g = (rr_ptr + k) % N;
    end
    exp_ready = (exp_g < 0) ? '0 : N'(1 << exp_g);
    exp_ceb   = !(exp_g >= 0 && int'(cur_a[exp_g]) < DEPTH);
    #1;
  endtask

  task automatic tick();
    logic oor;
    @(posedge CLK);
    exp_rv = '0; exp_err = 1'b0; exp_data = '0;
    if (exp_g >= 0) begin
      oor = (int'(cur_a[exp_g]) >= DEPTH);
      if (!cur_w[exp_g]) begin
        exp_rv   = N'(1 << exp_g);
        exp_err  = oor;
        exp_data = oor ? '0 : ref_mem[cur_a[exp_g]];
      end else if (!oor) begin
        ref_mem[cur_a[exp_g]] = cur_d[exp_g];
      end
      rr_ptr = (exp_g + 1) % N;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    drive('0, '0, '0, '0, '0, '0);
    tick();
  endtask

  // Assert RST for one edge, then wait (bounded) for init_done while holding 'hold' on req_valid.
  task automatic do_reset(input logic [N-1:0] hold);
    RST = 1'b1;
    req_valid = '0;
    @(posedge CLK);
    rr_ptr = 0; exp_g = -1; exp_rv = '0; exp_err = 1'b0; exp_data = '0;
`ifdef SRAM_ARB_INIT_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    @(negedge CLK);
    RST = 1'b0;
    req_valid = hold;
    init_cycles = 0;
    ready_viol = 0;
    while (!init_done && init_cycles < DEPTH + 100) begin
      #1;
      if (req_ready !== '0) ready_viol++;
      @(negedge CLK);
      init_cycles++;
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    req_valid = 2'b11; req_we = 2'b01; req_addr = {13'd7, 13'd9}; req_wdata = {16'h1111, 16'h2222};
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (mem_CEB !== 1'b1) begin errors++; $display("FAIL reset_ceb: got %b want 1", mem_CEB); end
    checks++; if (mem_WEB !== 1'b1 || mem_A !== '0 || mem_D !== '0) begin
      errors++; $display("FAIL reset_mem_pins: got WEB=%b A=%h D=%h want 1/0/0", mem_WEB, mem_A, mem_D); end
    checks++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_data !== '0) begin
      errors++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_err, rsp_data); end
    do_reset('0);
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reset_init_done: got %b want 1", init_done); end
`ifdef SRAM_ARB_INIT_EN
    checks++; if (init_cycles !== DEPTH) begin errors++; $display("FAIL reset_init_cycles: got %0d want %0d", init_cycles, DEPTH); end
`else
    checks++; if (init_cycles !== 0) begin errors++; $display("FAIL reset_init_cycles: got %0d want 0", init_cycles); end
`endif
  endtask

  task automatic test_same_cycle_read();
    do_reset('0);
    drive(2'b10, 2'b10, '0, 13'd5, '0, 16'h5A5A);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL prefill_ready: got %b want 10", req_ready); end
    tick();
    drive(2'b11, 2'b00, 13'd5, 13'd5, '0, '0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL both_first_ready: got %b want 01", req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h5A5A) begin
      errors++; $display("FAIL both_first_rsp: got v=%b d=%h want 01/5a5a", rsp_valid, rsp_data); end
    drive(2'b10, 2'b00, 13'd5, 13'd5, '0, '0);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL both_second_ready: got %b want 10", req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 16'h5A5A) begin
      errors++; $display("FAIL both_second_rsp: got v=%b d=%h want 10/5a5a", rsp_valid, rsp_data); end
    idle();
  endtask

  task automatic test_write_then_read();
    drive(2'b01, 2'b01, 13'h0400, '0, 16'hBEEF, '0);
    checks++; if (req_ready !== 2'b01 || mem_CEB !== 1'b0 || mem_WEB !== 1'b0) begin
      errors++; $display("FAIL wr_issue: got rdy=%b ceb=%b web=%b want 01/0/0", req_ready, mem_CEB, mem_WEB); end
    tick();
    drive(2'b10, 2'b00, '0, 13'h0400, '0, '0);
    checks++; if (req_ready !== 2'b10 || mem_CEB !== 1'b0 || mem_WEB !== 1'b1) begin
      errors++; $display("FAIL rd_issue: got rdy=%b ceb=%b web=%b want 10/0/1", req_ready, mem_CEB, mem_WEB); end
    tick();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0) begin
      errors++; $display("FAIL wr_rd_rsp: got v=%b d=%h e=%b want 10/beef/0", rsp_valid, rsp_data, rsp_err); end
    idle();
  endtask

  task automatic test_out_of_range();
    drive(2'b01, 2'b00, 13'h1800, '0, '0, '0);
    checks++; if (mem_CEB !== 1'b1 || req_ready !== 2'b01) begin
      errors++; $display("FAIL oor_rd_issue: got ceb=%b rdy=%b want 1/01", mem_CEB, req_ready); end
    tick();
    checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== '0) begin
      errors++; $display("FAIL oor_rd_rsp: got v=%b e=%b d=%h want 01/1/0", rsp_valid, rsp_err, rsp_data); end
    drive(2'b01, 2'b01, 13'h1805, '0, 16'hDEAD, '0);
    checks++; if (mem_CEB !== 1'b1) begin errors++; $display("FAIL oor_wr_ceb: got %b want 1", mem_CEB); end
    tick();
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL oor_wr_rsp: got %b want 00", rsp_valid); end
  endtask

  task automatic test_fairness();
    int prev;
    do_reset('0);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b00, 13'd5, 13'h0400, '0, '0);
      checks++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10) || exp_g == prev) begin
        errors++; $display("FAIL fair_grant%0d: got %b want %b", i, req_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
      prev = exp_g;
      tick();
      checks++; if (rsp_valid !== exp_rv || rsp_data !== exp_data) begin
        errors++; $display("FAIL fair_rsp%0d: got v=%b d=%h want %b/%h", i, rsp_valid, rsp_data, exp_rv, exp_data); end
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    drive(2'b01, 2'b00, 13'd5, '0, '0, '0);
    tick();
    RST = 1'b1;
    #1;
    checks++; if (mem_CEB !== 1'b1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rst_hold: got ceb=%b rdy=%b want 1/00", mem_CEB, req_ready); end
    do_reset('0);
    checks++; if (rsp_valid !== 2'b00 || mem_CEB !== 1'b1) begin
      errors++; $display("FAIL rst_drop: got v=%b ceb=%b want 00/1", rsp_valid, mem_CEB); end
    drive(2'b11, 2'b00, 13'd5, 13'd5, '0, '0);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_ptr: got %b want 01", req_ready); end
    tick();
    idle();
  endtask

`ifdef SRAM_ARB_INIT_EN
  task automatic test_init_sweep();
    logic [AW-1:0] probe [3];
    probe[0] = 13'd0; probe[1] = 13'd1023; probe[2] = 13'd6143;
    sram[0] = 16'hA5A5; sram[1023] = 16'h5A5A; sram[6143] = 16'h1234;
    req_addr = {13'd1023, 13'd0};
    do_reset(2'b11);
    checks++; if (ready_viol !== 0 || init_cycles !== DEPTH) begin
      errors++; $display("FAIL init_window: got viol=%0d cycles=%0d want 0/%0d", ready_viol, init_cycles, DEPTH); end
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 2'b00, probe[i], '0, '0, '0);
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 16'h0000) begin
        errors++; $display("FAIL init_zero%0d: got v=%b d=%h want 01/0000", i, rsp_valid, rsp_data); end
    end
  endtask
`endif

  task automatic test_random();
    logic [AW-1:0] pool [8];
    logic [N-1:0]  nv, nw;
    logic [AW-1:0] na [N];
    logic [DW-1:0] nd [N];
    pool[0] = 13'd0; pool[1] = AW'(DEPTH - 1);
    for (int p = 2; p < 8; p++) pool[p] = AW'($urandom_range(0, DEPTH - 1));
    for (int p = 0; p < 8; p++) begin
      drive(2'b01, 2'b01, pool[p], '0, DW'($urandom), '0);
      tick();
    end
    nv = '0; nw = '0;
    for (int j = 0; j < N; j++) begin na[j] = '0; nd[j] = '0; end
    for (int c = 0; c < 200; c++) begin
      for (int j = 0; j < N; j++) begin
        if (!(cur_v[j] && exp_g != j)) begin
          nv[j] = ($urandom_range(0, 3) != 0);
          nw[j] = $urandom_range(0, 1) == 1;
          na[j] = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + $urandom_range(0, 2047))
                                              : pool[$urandom_range(0, 7)];
          nd[j] = DW'($urandom);
        end
      end
      drive(nv, nw, na[0], na[1], nd[0], nd[1]);
      checks++; if (req_ready !== exp_ready || mem_CEB !== exp_ceb) begin
        errors++; $display("FAIL rnd_issue%0d: got rdy=%b ceb=%b want %b/%b", c, req_ready, mem_CEB, exp_ready, exp_ceb); end
      if (exp_g >= 0 && !exp_ceb) begin
        checks++; if (mem_A !== cur_a[exp_g] || mem_WEB !== !cur_w[exp_g] || (cur_w[exp_g] && mem_D !== cur_d[exp_g])) begin
          errors++; $display("FAIL rnd_pins%0d: got A=%h WEB=%b D=%h want %h/%b/%h", c, mem_A, mem_WEB, mem_D,
                             cur_a[exp_g], !cur_w[exp_g], cur_d[exp_g]); end
      end
      tick();
      checks++; if (rsp_valid !== exp_rv || (exp_rv != '0 && (rsp_err !== exp_err || rsp_data !== exp_data))) begin
        errors++; $display("FAIL rnd_rsp%0d: got v=%b e=%b d=%h want %b/%b/%h", c, rsp_valid, rsp_err, rsp_data,
                           exp_rv, exp_err, exp_data); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = DW'($urandom);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rr_ptr = 0; exp_g = -1; exp_rv = '0; exp_err = 1'b0; exp_data = '0;
    cur_v = '0; cur_w = '0;
    test_reset();
    test_same_cycle_read();
    test_write_then_read();
    test_out_of_range();
    test_fairness();
    test_reset_inflight();
`ifdef SRAM_ARB_INIT_EN
    test_init_sweep();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
